// File: rtl/lcd_wb_ctrl.sv
// lcd_wb_ctrl: Wishbone front end for the LCD PHY.
// Bus writes of commands, data bytes and RGB565 pixels go into a byte FIFO
// tagged with RS, and the FIFO streams to the PHY over valid/ready. The block
// also holds the LCD control bits and the sticky frame-mark and overflow flags.
module lcd_wb_ctrl #(
    parameter int FIFO_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic [1:0]  wb_addr,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic [7:0]  phy_data,
    output logic        phy_rs,
    output logic        phy_valid,
    input  logic        phy_ready,
    output logic        phy_ena,
    output logic        phy_rst,
    output logic        phy_cs,
    input  logic        phy_mode,
    input  logic        phy_fmark_stb
);

    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int LW     = FIFO_LOG2 + 1;
    localparam int DATA_W = 8;

    // FIFO storage: {rs, byte}
    logic [DATA_W:0]     mem [DEPTH];
    logic [FIFO_LOG2-1:0] wptr, rptr;
    logic [LW-1:0]        level;

    // Pending pixel LSB, pushed the cycle after the MSB
    logic                pend_vld_p1;
    logic [DATA_W-1:0]   pend_byte_p1;

    logic ena_r, rst_r, cs_r;
    logic fmark_r, ovf_r;

    logic          req, wr, csr_wr, flush, pop;
    logic          push, pend_set, ovf_set;
    logic [DATA_W:0] push_word;
    logic [LW:0]   occ;
    logic          room1, room2;
    logic [31:0]   status;
    logic          unused_wdata;

    assign unused_wdata = ^wb_wdata[31:16];

    assign req    = wb_cyc & ~wb_ack;
    assign wr     = req & wb_we;
    assign csr_wr = wr & (wb_addr == 2'd0);
    assign flush  = csr_wr & wb_wdata[4];

    // Pending LSB already holds a reserved slot
    assign occ   = {1'b0, level} + (LW+1)'(pend_vld_p1);
    assign room1 = occ <  (LW+1)'(DEPTH);
    assign room2 = occ <= (LW+1)'(DEPTH - 2);

    assign phy_valid = (level != '0);
    assign phy_data  = mem[rptr][DATA_W-1:0];
    assign phy_rs    = mem[rptr][DATA_W];
    assign pop       = phy_valid & phy_ready & ~flush;

    assign phy_ena = ena_r;
    assign phy_rst = rst_r;
    assign phy_cs  = cs_r;

    // Push selection: pending pixel LSB first, then new bus writes
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        pend_set  = 1'b0;
        ovf_set   = 1'b0;
        if (pend_vld_p1) begin
            push      = 1'b1;
            push_word = {1'b1, pend_byte_p1};
        end else if (wr && (wb_addr == 2'd1 || wb_addr == 2'd2)) begin
            if (room1) begin
                push      = 1'b1;
                push_word = {(wb_addr == 2'd2), wb_wdata[7:0]};
            end else begin
                ovf_set = 1'b1;
            end
        end else if (wr && wb_addr == 2'd3) begin
            if (room2) begin
                push      = 1'b1;
                push_word = {1'b1, wb_wdata[15:8]};
                pend_set  = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    // Status word as seen by a CSR read
    always_comb begin
        status            = '0;
        status[0]         = ena_r;
        status[1]         = rst_r;
        status[2]         = cs_r;
        status[3]         = phy_mode;
        status[4]         = fmark_r;
        status[5]         = ovf_r;
        status[8]         = (level == '0);
        status[9]         = (level == LW'(DEPTH));
        status[16 +: LW]  = level;
    end

    // Control state: bus handshake, pointers, level, CSR bits, sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack      <= 1'b0;
            wb_rdata    <= '0;
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            pend_vld_p1 <= 1'b0;
            ena_r       <= 1'b0;
            rst_r       <= 1'b1;
            cs_r        <= 1'b0;
            fmark_r     <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            wb_ack   <= req;
            wb_rdata <= (req && !wb_we && wb_addr == 2'd0) ? status : '0;
            if (flush) begin
                wptr        <= '0;
                rptr        <= '0;
                level       <= '0;
                pend_vld_p1 <= 1'b0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                level       <= level + LW'(push) - LW'(pop);
                pend_vld_p1 <= pend_set;
            end
            if (csr_wr) begin
                ena_r <= wb_wdata[0];
                rst_r <= wb_wdata[1];
                cs_r  <= wb_wdata[2];
            end
            if (phy_fmark_stb)
                fmark_r <= 1'b1;
            else if (csr_wr && wb_wdata[3])
                fmark_r <= 1'b0;
            if (ovf_set)
                ovf_r <= 1'b1;
            else if (csr_wr && wb_wdata[5])
                ovf_r <= 1'b0;
        end
    end

    // Datapath: FIFO storage and pixel LSB holding register (no reset)
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= push_word;
        if (pend_set) pend_byte_p1 <= wb_wdata[7:0];
    end

endmodule

// File: tb/tb_lcd_wb_ctrl.sv
// Directed testbench for lcd_wb_ctrl (FIFO_LOG2 = 4).
module tb_lcd_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_wdata;
    logic [31:0] wb_rdata;
    logic [1:0]  wb_addr;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic [7:0]  phy_data;
    logic        phy_rs;
    logic        phy_valid;
    logic        phy_ready;
    logic        phy_ena;
    logic        phy_rst;
    logic        phy_cs;
    logic        phy_mode;
    logic        phy_fmark_stb;

    int total = 0;
    int bad   = 0;

    // Head snapshot taken one cycle after a request executes
    logic       snap_valid;
    logic [7:0] snap_data;
    logic       snap_rs;
    logic [31:0] rd;

    lcd_wb_ctrl #(.FIFO_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_addr(wb_addr),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .phy_data(phy_data), .phy_rs(phy_rs), .phy_valid(phy_valid),
        .phy_ready(phy_ready), .phy_ena(phy_ena), .phy_rst(phy_rst),
        .phy_cs(phy_cs), .phy_mode(phy_mode), .phy_fmark_stb(phy_fmark_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge
    task automatic bus_op(input logic we, input logic [1:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata);
        wb_cyc   = 1'b1;
        wb_we    = we;
        wb_addr  = addr;
        wb_wdata = data;
        @(posedge clk);
        @(negedge clk);
        chk("ack_high", {31'd0, wb_ack}, 32'd1);
        rdata      = wb_rdata;
        snap_valid = phy_valid;
        snap_data  = phy_data;
        snap_rs    = phy_rs;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ack_low", {31'd0, wb_ack}, 32'd0);
        chk("rdata_idle", wb_rdata, 32'd0);
    endtask

    task automatic wb_write(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_op(1'b1, addr, data, dummy);
    endtask

    task automatic wb_read(input logic [1:0] addr, output logic [31:0] data);
        bus_op(1'b0, addr, 32'd0, data);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdata = 32'd0;
        phy_ready = 1'b0; phy_mode = 1'b0; phy_fmark_stb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_valid", {31'd0, phy_valid}, 32'd0);
        chk("rst_phy_rst", {31'd0, phy_rst}, 32'd1);
        chk("rst_phy_ena", {31'd0, phy_ena}, 32'd0);
        wb_read(2'd0, rd);
        chk("rst_csr", rd, 32'h0000_0102);

        // Command + data stream, each byte at head one cycle after its push
        phy_ready = 1'b1;
        wb_write(2'd1, 32'h2A);
        chk("cmd_head", {22'd0, snap_valid, snap_rs, snap_data}, {22'd0, 1'b1, 1'b0, 8'h2A});
        wb_write(2'd2, 32'h00);
        chk("dat0_head", {22'd0, snap_valid, snap_rs, snap_data}, {22'd0, 1'b1, 1'b1, 8'h00});
        wb_write(2'd2, 32'hEF);
        chk("dat1_head", {22'd0, snap_valid, snap_rs, snap_data}, {22'd0, 1'b1, 1'b1, 8'hEF});
        chk("stream_drained", {31'd0, phy_valid}, 32'd0);

        // Pixel split
        phy_ready = 1'b0;
        wb_write(2'd3, 32'h0000_F81F);
        wb_read(2'd0, rd);
        chk("pix_level2", rd, 32'h0002_0002);
        phy_ready = 1'b1;
        chk("pix_msb", {23'd0, phy_rs, phy_data}, {23'd0, 1'b1, 8'hF8});
        cycle();
        chk("pix_lsb", {23'd0, phy_rs, phy_data}, {23'd0, 1'b1, 8'h1F});
        cycle();
        chk("pix_empty", {31'd0, phy_valid}, 32'd0);
        phy_ready = 1'b0;

        // Reads of data addresses return 0
        wb_read(2'd1, rd);
        chk("rd_addr1", rd, 32'd0);

        // Overflow and pointer wrap (pointers start at 5)
        for (int i = 0; i < 16; i++) wb_write(2'd2, 32'h10 + i);
        wb_read(2'd0, rd);
        chk("full16", rd, 32'h0010_0202);
        wb_write(2'd2, 32'hEE);
        wb_read(2'd0, rd);
        chk("ovf_drop", rd, 32'h0010_0222);
        chk("head_before_pop", {24'd0, phy_data}, 32'h10);
        phy_ready = 1'b1;
        cycle();
        phy_ready = 1'b0;
        wb_write(2'd3, 32'h0000_ABCD);
        wb_read(2'd0, rd);
        chk("pix_drop_l15", rd, 32'h000F_0022);
        phy_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("drain_%0d", i), {23'd0, phy_valid, phy_data},
                {23'd0, 1'b1, 8'h11 + 8'(i)});
            cycle();
        end
        chk("drain_empty", {31'd0, phy_valid}, 32'd0);
        phy_ready = 1'b0;
        wb_write(2'd0, 32'h22);
        wb_read(2'd0, rd);
        chk("ovf_clear", rd, 32'h0000_0102);

        // CSR control outputs and mode status
        wb_write(2'd0, 32'h05);
        chk("csr_ctrl", {29'd0, phy_cs, phy_rst, phy_ena}, 32'h5);
        phy_mode = 1'b1;
        wb_read(2'd0, rd);
        chk("csr_mode", rd, 32'h0000_010D);
        phy_mode = 1'b0;
        wb_write(2'd0, 32'h02);

        // Frame-mark sticky
        phy_fmark_stb = 1'b1;
        cycle();
        phy_fmark_stb = 1'b0;
        wb_read(2'd0, rd);
        chk("fmark_set", rd, 32'h0000_0112);
        phy_fmark_stb = 1'b1;
        wb_write(2'd0, 32'h0A);
        phy_fmark_stb = 1'b0;
        wb_read(2'd0, rd);
        chk("fmark_set_wins", rd, 32'h0000_0112);
        wb_write(2'd0, 32'h0A);
        wb_read(2'd0, rd);
        chk("fmark_clear", rd, 32'h0000_0102);

        // Flush concurrent with a pop
        for (int i = 1; i <= 7; i++) wb_write(2'd2, i);
        phy_ready = 1'b1;
        cycle();
        cycle();
        phy_ready = 1'b0;
        wb_read(2'd0, rd);
        chk("pre_flush_level", rd, 32'h0005_0002);
        chk("pre_flush_head", {24'd0, phy_data}, 32'h03);
        phy_ready = 1'b1;
        wb_write(2'd0, 32'h12);
        chk("flush_valid", {31'd0, snap_valid}, 32'd0);
        phy_ready = 1'b0;
        wb_read(2'd0, rd);
        chk("flush_level", rd, 32'h0000_0102);
        wb_write(2'd2, 32'h55);
        chk("post_flush_head", {22'd0, snap_valid, snap_rs, snap_data}, {22'd0, 1'b1, 1'b1, 8'h55});
        wb_read(2'd0, rd);
        chk("post_flush_level", rd, 32'h0001_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
